// File: rtl/vec_pkg.sv
// Shared constants and FSM state type for the vector lane sequencer.
package vec_pkg;

  localparam int VEC_N     = 32;                  // element width
  localparam int VEC_V     = 20;                  // vector length
  localparam int VEC_LANES = 4;                   // parallel ALU lanes
  localparam int VEC_BEATS = VEC_V / VEC_LANES;   // issue beats per vector
  localparam int BEAT_W    = 3;                   // width of beat/return counters

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } vec_state_e;

endpackage

// File: rtl/vec_lane_mux.sv
// Operand selection: picks each lane's A/B operand for the current beat.
// Lane L works on the contiguous slice L*BEATS .. L*BEATS+BEATS-1.
module vec_lane_mux
  import vec_pkg::*;
#(
  parameter int N     = VEC_N,
  parameter int V     = VEC_V,
  parameter int LANES = VEC_LANES
) (
  input  logic [BEAT_W-1:0]         beat,
  input  logic                      vv,
  input  logic [V-1:0][N-1:0]       rd1,
  input  logic [V-1:0][N-1:0]       rd2,
  input  logic [N-1:0]              scalar,
  output logic [LANES-1:0][N-1:0]   lane_a,
  output logic [LANES-1:0][N-1:0]   lane_b
);

  localparam int BEATS = V / LANES;
  localparam int IW    = $clog2(V);

  // Per-lane element select; B falls back to the scalar for vector-scalar ops.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = rd1[IW'(l * BEATS) + IW'(beat)];
      lane_b[l] = vv ? rd2[IW'(l * BEATS) + IW'(beat)] : scalar;
    end
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Vector lane sequencer: latches a vector op, issues it to LANES ALU lanes
// over BEATS beats, collects in-order results and writes the vector back.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a new op; start_i accepted here only
//   ST_ISSUE | presenting beat operands, advancing on each non-stalled beat
//   ST_WAIT  | all beats issued, waiting for remaining ALU returns
//   ST_WB    | one-cycle write-back pulse, result vector now valid
module vec_lane_sequencer
  import vec_pkg::*;
#(
  parameter int N     = VEC_N,
  parameter int V     = VEC_V,
  parameter int LANES = VEC_LANES
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start_i,
  output logic                      ready_o,
  input  logic [1:0]                op_type_i,
  input  logic [V-1:0][N-1:0]       rd1_vec_i,
  input  logic [V-1:0][N-1:0]       rd2_vec_i,
  input  logic [N-1:0]              scalar_i,
  output logic [LANES-1:0][N-1:0]   lane_a_o,
  output logic [LANES-1:0][N-1:0]   lane_b_o,
  output logic                      lane_valid_o,
  input  logic                      lane_stall_i,
  input  logic [LANES-1:0][N-1:0]   lane_res_i,
  input  logic                      lane_res_valid_i,
  output logic [BEAT_W-1:0]         beat_o,
  output logic [V-1:0][N-1:0]       wb_vec_o,
  output logic                      wb_en_o,
  output logic                      done_o,
  output logic                      busy_o
);

  localparam int BEATS = V / LANES;
  localparam int IW    = $clog2(V);
  localparam logic [BEAT_W-1:0] BEATS_C   = BEAT_W'(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  vec_state_e state, state_nxt;

  logic [BEAT_W-1:0]         beat;
  logic [BEAT_W-1:0]         ret;
  logic                      vv_q;
  logic [V-1:0][N-1:0]       rd1_q;
  logic [V-1:0][N-1:0]       rd2_q;
  logic [N-1:0]              scalar_q;
  logic [V-1:0][N-1:0]       res_buf;
  logic [LANES-1:0][N-1:0]   mux_a;
  logic [LANES-1:0][N-1:0]   mux_b;
  logic                      accept;
  logic                      issue;
  logic                      ret_adv;
  logic                      op_type_unused;

  // Only bit0 selects the operand form; bit1 carries no meaning here.
  assign op_type_unused = op_type_i[1];

  assign accept  = (state == ST_IDLE) & start_i;
  assign issue   = (state == ST_ISSUE) & ~lane_stall_i;
  // Returns beyond BEATS (or outside ISSUE/WAIT) are dropped.
  assign ret_adv = lane_res_valid_i & ((state == ST_ISSUE) | (state == ST_WAIT)) & (ret != BEATS_C);

  vec_lane_mux #(.N(N), .V(V), .LANES(LANES)) u_lane_mux (
    .beat   (beat),
    .vv     (vv_q),
    .rd1    (rd1_q),
    .rd2    (rd2_q),
    .scalar (scalar_q),
    .lane_a (mux_a),
    .lane_b (mux_b)
  );

  assign lane_a_o = lane_valid_o ? mux_a : '0;
  assign lane_b_o = lane_valid_o ? mux_b : '0;
  assign beat_o   = beat;

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and status outputs. WAIT->WB looks at the registered return
  // count, so a final return coinciding with the last issue still spends a
  // cycle in WAIT.
  always_comb begin
    state_nxt    = state;
    ready_o      = 1'b0;
    busy_o       = 1'b1;
    lane_valid_o = 1'b0;
    wb_en_o      = 1'b0;
    done_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (start_i) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        lane_valid_o = 1'b1;
        if (!lane_stall_i && (beat == LAST_BEAT)) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ret == BEATS_C) state_nxt = ST_WB;
      end
      ST_WB: begin
        wb_en_o   = 1'b1;
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latches and beat counter.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      vv_q     <= 1'b0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      scalar_q <= '0;
      beat     <= '0;
    end else if (accept) begin
      vv_q     <= op_type_i[0];
      rd1_q    <= rd1_vec_i;
      rd2_q    <= rd2_vec_i;
      scalar_q <= scalar_i;
      beat     <= '0;
    end else if (issue) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
    end
  end

  // Result assembly into a scratch buffer; wb_vec_o only changes entering WB.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ret      <= '0;
      res_buf  <= '0;
      wb_vec_o <= '0;
    end else begin
      if (accept) begin
        ret <= '0;
      end else if (ret_adv) begin
        for (int l = 0; l < LANES; l++) begin
          res_buf[IW'(l * BEATS) + IW'(ret)] <= lane_res_i[l];
        end
        ret <= ret + BEAT_W'(1);
      end
      if (state_nxt == ST_WB) wb_vec_o <= res_buf;
    end
  end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Randomised bench for vec_lane_sequencer with a transaction-level model:
// an ALU of configurable fixed latency, in-order result queue, and expected
// operands/results computed straight from the vector definitions.
module tb_vec_lane_sequencer;
  import vec_pkg::*;

  localparam int CW = VEC_V * VEC_N;
  localparam int IW = $clog2(VEC_V);

  logic                              CLK = 1'b0;
  logic                              RST;
  logic                              start_i;
  logic                              ready_o;
  logic [1:0]                        op_type_i;
  logic [VEC_V-1:0][VEC_N-1:0]       rd1_vec_i;
  logic [VEC_V-1:0][VEC_N-1:0]       rd2_vec_i;
  logic [VEC_N-1:0]                  scalar_i;
  logic [VEC_LANES-1:0][VEC_N-1:0]   lane_a_o;
  logic [VEC_LANES-1:0][VEC_N-1:0]   lane_b_o;
  logic                              lane_valid_o;
  logic                              lane_stall_i;
  logic [VEC_LANES-1:0][VEC_N-1:0]   lane_res_i;
  logic                              lane_res_valid_i;
  logic [BEAT_W-1:0]                 beat_o;
  logic [VEC_V-1:0][VEC_N-1:0]       wb_vec_o;
  logic                              wb_en_o;
  logic                              done_o;
  logic                              busy_o;

  vec_lane_sequencer dut (
    .CLK              (CLK),
    .RST              (RST),
    .start_i          (start_i),
    .ready_o          (ready_o),
    .op_type_i        (op_type_i),
    .rd1_vec_i        (rd1_vec_i),
    .rd2_vec_i        (rd2_vec_i),
    .scalar_i         (scalar_i),
    .lane_a_o         (lane_a_o),
    .lane_b_o         (lane_b_o),
    .lane_valid_o     (lane_valid_o),
    .lane_stall_i     (lane_stall_i),
    .lane_res_i       (lane_res_i),
    .lane_res_valid_i (lane_res_valid_i),
    .beat_o           (beat_o),
    .wb_vec_o         (wb_vec_o),
    .wb_en_o          (wb_en_o),
    .done_o           (done_o),
    .busy_o           (busy_o)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [VEC_V-1:0][VEC_N-1:0]     m_rd1, m_rd2, wb_prev;
  logic [VEC_N-1:0]                m_sc;
  logic                            m_vv;
  logic [VEC_LANES-1:0][VEC_N-1:0] q_res[$];
  int                              q_due[$];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_V-1:0][VEC_N-1:0] rand_vec();
    logic [VEC_V-1:0][VEC_N-1:0] r;
    for (int i = 0; i < VEC_V; i++) r[i] = $urandom;
    return r;
  endfunction

  function automatic logic [VEC_LANES-1:0][VEC_N-1:0] rand_lanes();
    logic [VEC_LANES-1:0][VEC_N-1:0] r;
    for (int l = 0; l < VEC_LANES; l++) r[l] = $urandom;
    return r;
  endfunction

  task automatic scramble_inputs();
    rd1_vec_i = rand_vec();
    rd2_vec_i = rand_vec();
    scalar_i  = $urandom;
    op_type_i = 2'($urandom_range(0, 3));
  endtask

  // One op from the IDLE cycle through WB (or an abort by reset).
  // smode: 0 no stalls, 1 stall 3 cycles on beat 2, 2 random stalls.
  task automatic run_op(input bit vv, input int lat, input int smode, input bit hold,
                        input int exp_len, input int abort_at, input bit directed);
    int issued, returned, last_ret, stall_cnt, c;
    bit fin, aborted, exp_valid, exp_done, stall;
    logic [VEC_LANES-1:0][VEC_N-1:0] ea, eb, sum;
    logic [VEC_V-1:0][VEC_N-1:0]     ewb;

    @(negedge CLK);
    chk("ready_idle", CW'(ready_o), CW'(1));
    chk("busy_idle", CW'(busy_o), CW'(0));
    chk("wb_hold_idle", CW'(wb_vec_o), CW'(wb_prev));
    if (directed) begin
      for (int i = 0; i < VEC_V; i++) begin
        rd1_vec_i[i] = VEC_N'(i);
        rd2_vec_i[i] = VEC_N'(100 + i);
      end
      scalar_i = 7;
    end else begin
      rd1_vec_i = rand_vec();
      rd2_vec_i = rand_vec();
      scalar_i  = $urandom;
    end
    op_type_i        = {1'($urandom_range(0, 1)), vv};
    start_i          = 1'b1;
    lane_stall_i     = 1'($urandom_range(0, 1));
    lane_res_valid_i = 1'b1;          // must be ignored while idle
    lane_res_i       = rand_lanes();
    m_rd1 = rd1_vec_i; m_rd2 = rd2_vec_i; m_sc = scalar_i; m_vv = vv;
    for (int i = 0; i < VEC_V; i++) ewb[i] = m_rd1[i] + (m_vv ? m_rd2[i] : m_sc);
    q_res.delete(); q_due.delete();
    issued = 0; returned = 0; last_ret = -100; stall_cnt = 0;
    fin = 0; aborted = 0;

    for (c = 1; c <= 80 && !fin; c++) begin
      @(negedge CLK);
      start_i = hold ? 1'b1 : 1'($urandom_range(0, 1));
      scramble_inputs();
      exp_valid = (issued < VEC_BEATS);
      exp_done  = (returned == VEC_BEATS) && (c == last_ret + 2);
      chk("busy", CW'(busy_o), CW'(1));
      chk("ready_busy", CW'(ready_o), CW'(0));
      chk("lane_valid", CW'(lane_valid_o), CW'(exp_valid));
      chk("done", CW'(done_o), CW'(exp_done));
      chk("wb_en", CW'(wb_en_o), CW'(exp_done));
      if (exp_valid) begin
        for (int l = 0; l < VEC_LANES; l++) begin
          ea[l] = m_rd1[IW'(l * VEC_BEATS + issued)];
          eb[l] = m_vv ? m_rd2[IW'(l * VEC_BEATS + issued)] : m_sc;
        end
        chk("beat", CW'(beat_o), CW'(issued));
        chk("lane_a", CW'(lane_a_o), CW'(ea));
        chk("lane_b", CW'(lane_b_o), CW'(eb));
      end
      if (exp_done) begin
        chk("wb_vec", CW'(wb_vec_o), CW'(ewb));
        if (exp_len > 0) chk("op_len", CW'(c), CW'(exp_len));
        wb_prev          = ewb;
        lane_stall_i     = 1'($urandom_range(0, 1));
        lane_res_valid_i = 1'b1;      // must be ignored in WB
        lane_res_i       = rand_lanes();
        fin = 1;
      end else begin
        chk("wb_hold", CW'(wb_vec_o), CW'(wb_prev));
        if (abort_at >= 0 && exp_valid && issued == abort_at) begin
          RST = 1'b0;
          lane_res_valid_i = 1'b0;
          aborted = 1; fin = 1;
        end else begin
          case (smode)
            1:       stall = exp_valid && (issued == 2) && (stall_cnt < 3);
            2:       stall = exp_valid && ($urandom_range(0, 2) == 0);
            default: stall = 1'b0;
          endcase
          if (stall) stall_cnt++;
          lane_stall_i = exp_valid ? stall : 1'($urandom_range(0, 1));
          if (exp_valid && !stall) begin
            for (int l = 0; l < VEC_LANES; l++) sum[l] = lane_a_o[l] + lane_b_o[l];
            q_res.push_back(sum);
            q_due.push_back(c + lat);
            issued++;
          end
          if (q_due.size() > 0 && q_due[0] == c) begin
            lane_res_i       = q_res.pop_front();
            void'(q_due.pop_front());
            lane_res_valid_i = 1'b1;
            returned++;
            last_ret = c;
          end else begin
            lane_res_i       = rand_lanes();
            lane_res_valid_i = (returned == VEC_BEATS) ? 1'($urandom_range(0, 1)) : 1'b0;
          end
        end
      end
    end
    chk("op_finished", CW'(fin), CW'(1));

    if (aborted) begin
      @(negedge CLK);
      RST = 1'b1;
      start_i = 1'b0;
      lane_res_valid_i = 1'b0;
      wb_prev = '0;
      chk("abort_ready", CW'(ready_o), CW'(1));
      chk("abort_busy", CW'(busy_o), CW'(0));
      chk("abort_valid", CW'(lane_valid_o), CW'(0));
      chk("abort_wb_en", CW'(wb_en_o), CW'(0));
      chk("abort_done", CW'(done_o), CW'(0));
      chk("abort_beat", CW'(beat_o), CW'(0));
      chk("abort_lane_a", CW'(lane_a_o), CW'(0));
      chk("abort_wb_vec", CW'(wb_vec_o), CW'(0));
    end
  endtask

  initial begin
    RST = 1'b0; start_i = 1'b0; op_type_i = '0;
    rd1_vec_i = '0; rd2_vec_i = '0; scalar_i = '0;
    lane_stall_i = 1'b0; lane_res_i = '0; lane_res_valid_i = 1'b0;
    wb_prev = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", CW'(ready_o), CW'(1));
    chk("rst_busy", CW'(busy_o), CW'(0));
    chk("rst_valid", CW'(lane_valid_o), CW'(0));
    chk("rst_done", CW'(done_o), CW'(0));
    chk("rst_wb_en", CW'(wb_en_o), CW'(0));
    chk("rst_beat", CW'(beat_o), CW'(0));
    chk("rst_lane_a", CW'(lane_a_o), CW'(0));
    chk("rst_lane_b", CW'(lane_b_o), CW'(0));
    chk("rst_wb_vec", CW'(wb_vec_o), CW'(0));
    RST = 1'b1;

    run_op(1'b1, 0, 0, 1'b0, 7, -1, 1'b1);    // vector-vector, directed operands
    run_op(1'b0, 0, 0, 1'b0, 7, -1, 1'b1);    // vector-scalar, scalar 7
    run_op(1'b1, 0, 1, 1'b0, 10, -1, 1'b0);   // 3-cycle stall on beat 2
    run_op(1'b1, 3, 0, 1'b0, 10, -1, 1'b0);   // ALU latency 3
    run_op(1'b1, 1, 0, 1'b1, 0, -1, 1'b0);    // start held high back to back
    run_op(1'b0, 2, 0, 1'b1, 0, -1, 1'b0);
    run_op(1'b1, 0, 0, 1'b0, 7, -1, 1'b0);
    run_op(1'b1, 1, 2, 1'b0, 0, 3, 1'b0);     // reset during beat 3
    run_op(1'b1, 0, 0, 1'b0, 7, -1, 1'b0);    // recovers after abort
    for (int k = 0; k < 12; k++) begin
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 4),
             ($urandom_range(0, 1) == 1) ? 2 : 0, 1'($urandom_range(0, 1)), 0, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
